// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
//   rpt_state_t     : auto-repeat FSM state encoding
//   DEF_*           : default channel count, repeat mask and timing constants
//   cnt_max()       : larger of two counts, used to size the repeat counter
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    localparam int unsigned DEF_N_BTN           = 5;
    localparam int unsigned DEF_REPEAT_MASK     = 32'h0000_0003;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;
    localparam int unsigned DEF_REPEAT_DELAY    = 6000000;
    localparam int unsigned DEF_REPEAT_RATE     = 1500000;

    function automatic int unsigned cnt_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-FF synchronizer, debounce filter, press pulse
// and optional hold-to-repeat.
//   clk, reset : clock, asynchronous active-high reset
//   btn_raw    : raw asynchronous button, active-high
//   enable     : 0 suppresses pulses and parks the repeat FSM in IDLE
//   level      : debounced button state
//   pulse      : one-cycle press / repeat strobe
//
// state     | meaning
// ST_IDLE   | no repeat in progress (permanent when REPEAT_EN = 0)
// ST_DELAY  | held since the press pulse, counting to the first repeat
// ST_REPEAT | counting between subsequent repeat pulses
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic enable,
    output logic level,
    output logic pulse
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RW = $clog2(cnt_max(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    logic          sync1, sync2;
    logic [DW-1:0] dcnt;
    logic          flip, rise, fall;
    rpt_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          pulse_nxt;

    // flip is true on the edge where the debounced level is about to toggle
    assign flip = (sync2 != level) && (dcnt == D_LAST);
    assign rise = flip & ~level;
    assign fall = flip & level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt  <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            dcnt <= '0;
        end else if (dcnt == D_LAST) begin
            level <= ~level;
            dcnt  <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        pulse_nxt = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            rcnt_nxt  = '0;
        end else begin
            pulse_nxt = rise;
            if (REPEAT_EN) begin
                unique case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state_nxt = ST_DELAY;
                            rcnt_nxt  = R_ONE;
                        end
                    end
                    ST_DELAY: begin
                        // a debounced release wins over a coinciding repeat
                        if (fall) begin
                            state_nxt = ST_IDLE;
                            rcnt_nxt  = '0;
                        end else if (rcnt == R_DELAY) begin
                            pulse_nxt = 1'b1;
                            state_nxt = ST_REPEAT;
                            rcnt_nxt  = R_ONE;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (fall) begin
                            state_nxt = ST_IDLE;
                            rcnt_nxt  = '0;
                        end else if (rcnt == R_RATE) begin
                            pulse_nxt = 1'b1;
                            rcnt_nxt  = R_ONE;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        rcnt_nxt  = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: N_BTN independent channels, each synchronized,
// debounced and turned into press pulses, with auto-repeat on the channels
// selected by REPEAT_MASK.
//   clk, reset : clock, asynchronous active-high reset
//   btn_raw    : raw asynchronous buttons, active-high
//   enable     : 1 = pulses permitted, 0 = pulses suppressed and repeat stopped
//   level      : debounced button states
//   pulse      : one-cycle press / repeat strobes
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned           N_BTN           = DEF_N_BTN,
    parameter int unsigned           DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned           REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned           REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [N_BTN-1:0]      REPEAT_MASK     = N_BTN'(DEF_REPEAT_MASK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .enable (enable),
            .level  (level[i]),
            .pulse  (pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RR = 4;
    localparam logic [NB-1:0] MASK = 5'b00011;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic          enable;
    logic [NB-1:0] level;
    logic [NB-1:0] pulse;

    int checks = 0;
    int failures = 0;

    button_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .enable (enable),
        .level  (level),
        .pulse  (pulse)
    );

    always #5 clk = ~clk;

    // Reference model: the last DC synchronized samples decide a level flip;
    // pulses are scheduled from the press time t0 by arithmetic.
    logic [NB-1:0] m_s1, m_s2, m_level, m_pulse;
    bit            hist [NB][$];
    bit            armed [NB];
    int            t0 [NB];
    int            edge_no = 0;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
        for (int i = 0; i < NB; i++) begin
            hist[i].delete();
            armed[i] = 0;
            t0[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] raw, input logic en);
        bit flip, rise, fall, p, all_diff;
        int dt;
        edge_no++;
        for (int i = 0; i < NB; i++) begin
            hist[i].push_back(m_s2[i]);
            if (hist[i].size() > DC) void'(hist[i].pop_front());
            all_diff = (hist[i].size() == DC);
            foreach (hist[i][j]) if (hist[i][j] == m_level[i]) all_diff = 0;
            flip = all_diff;
            rise = flip && !m_level[i];
            fall = flip && m_level[i];
            p = 0;
            if (rise && en) begin
                p = 1;
                if (MASK[i]) begin armed[i] = 1; t0[i] = edge_no; end
            end else if (armed[i]) begin
                if (!en || fall) armed[i] = 0;
                else begin
                    dt = edge_no - t0[i];
                    if (dt == RD || (dt > RD && (dt - RD) % RR == 0)) p = 1;
                end
            end
            if (flip) begin
                m_level[i] = ~m_level[i];
                hist[i].delete();
            end
            m_pulse[i] = p;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(btn_raw, enable);
        #1;
        checks++;
        assert (level === m_level) else begin
            failures++;
            $error("FAIL level edge=%0d observed=%b expected=%b", edge_no, level, m_level);
        end
        checks++;
        assert (pulse === m_pulse) else begin
            failures++;
            $error("FAIL pulse edge=%0d observed=%b expected=%b", edge_no, pulse, m_pulse);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, np, any;
        logic [31:0] pmask;

        reset = 1'b1; btn_raw = '0; enable = 1'b1;
        model_reset();
        #1; chk("reset_level", {27'd0, level}, 32'd0);
        chk("reset_pulse", {27'd0, pulse}, 32'd0);
        step(); step();
        reset = 1'b0;

        // 1: idle
        any = 0;
        for (int s = 0; s < 20; s++) begin step(); if (level != 0 || pulse != 0) any = 1; end
        chk("t1_quiet", any, 0);

        // 2: ch2 press / release, no repeat
        btn_raw[2] = 1'b1; first = 0; np = 0;
        for (int s = 1; s <= 50; s++) begin
            step();
            if (level[2] && first == 0) first = s;
            if (pulse[2]) np++;
        end
        chk("t2_rise_step", first, 6);
        chk("t2_pulses", np, 1);
        btn_raw[2] = 1'b0; first = 0; np = 0;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (!level[2] && first == 0) first = s;
            if (pulse[2]) np++;
        end
        chk("t2_fall_step", first, 6);
        chk("t2_fall_pulses", np, 0);

        // 3: short glitch on ch0
        btn_raw[0] = 1'b1; any = 0;
        for (int s = 0; s < 3; s++) begin step(); if (level[0] || pulse[0]) any = 1; end
        btn_raw[0] = 1'b0;
        for (int s = 0; s < 10; s++) begin step(); if (level[0] || pulse[0]) any = 1; end
        chk("t3_glitch", any, 0);

        // 4: ch0 hold with auto-repeat
        btn_raw[0] = 1'b1; first = -1;
        for (int s = 0; s < 20 && first < 0; s++) begin
            step();
            if (level[0]) first = 0;
        end
        chk("t4_rose", first, 0);
        pmask = 32'd1 & {31'd0, pulse[0]};
        for (int off = 1; off <= 30; off++) begin
            step();
            if (pulse[0] && off < 32) pmask[off] = 1'b1;
        end
        chk("t4_pulse_offsets", pmask, 32'h1111_1101);
        btn_raw[0] = 1'b0; np = 0;
        for (int s = 0; s < 25; s++) begin step(); if (!level[0] && pulse[0]) np++; end
        chk("t4_after_release", np, 0);
        chk("t4_level_low", {31'd0, level[0]}, 0);

        // 5: enable gating on ch1
        enable = 1'b0; btn_raw[1] = 1'b1; np = 0;
        for (int s = 0; s < 10; s++) begin step(); if (pulse[1]) np++; end
        chk("t5_level_while_disabled", {31'd0, level[1]}, 1);
        enable = 1'b1;
        for (int s = 0; s < 15; s++) begin step(); if (pulse[1]) np++; end
        chk("t5_no_pulse_on_enable", np, 0);
        btn_raw[1] = 1'b0;
        for (int s = 0; s < 10; s++) step();
        btn_raw[1] = 1'b1; np = 0;
        for (int s = 0; s < 20; s++) begin step(); if (pulse[1]) np++; end
        chk("t5_repress_pulses", np, 3);
        btn_raw[1] = 1'b0;
        for (int s = 0; s < 10; s++) step();

        // 6: simultaneous press, then reset during ch0 DELAY
        btn_raw[0] = 1'b1; btn_raw[4] = 1'b1;
        for (int s = 0; s < 6; s++) step();
        chk("t6_both_pulse", {30'd0, pulse[4], pulse[0]}, 32'd3);
        for (int s = 0; s < 3; s++) step();
        reset = 1'b1; #1;
        model_reset();
        chk("t6_async_level", {27'd0, level}, 0);
        chk("t6_async_pulse", {27'd0, pulse}, 0);
        step(); step();
        reset = 1'b0; first = 0;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (pulse[0] && first == 0) first = s;
        end
        chk("t6_post_reset_pulse_step", first, 6);
        btn_raw = '0;
        for (int s = 0; s < 10; s++) step();

        // random phase against the model
        for (int s = 0; s < 1600; s++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, (s < 800) ? 7 : 29) == 0) btn_raw[i] = ~btn_raw[i];
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
